alu_pipe_fu: RTL and testbench
==============================

# alu_pipe_fu

Parametrised, pipelined integer ALU functional unit. It is the successor to the single-cycle ALU FU. Operands are accepted from the issue stage and carried through `STAGES` register stages with a valid/grant handshake toward the CDB arbiter. Speculative entries are squashed or have their branch-mask bits cleared in every stage on branch resolution. It sits between the RS issue port and the CDB, alongside the pipelined multiplier.

## Interface
Parameters:
- `XLEN`, 64: operand/result width.
- `STAGES`, 2: pipeline depth (1..8); issue-to-done latency in cycles.
- `BR_DEPTH`, 4: branch-mask width (branch stack entries).
- `PREG_W`, 6: physical register tag width.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `fus_en`, in, 1: issue valid this cycle.
- `fus_opA`, `fus_opB`, in, XLEN each: operands, already muxed (reg/imm/NPC).
- `fus_func`, in, 5: ALU function code (`ALU_*` encodings).
- `fus_tagDest`, in, PREG_W: destination physical tag.
- `fus_bmask`, in, BR_DEPTH: branch mask of issuing op.
- `br_branch_resolved`, in, 1: a branch resolves this cycle.
- `br_pred_wrong`, in, 1: that branch mispredicted.
- `br_bs_ptr`, in, log2(BR_DEPTH): branch-stack index of resolving branch.
- `cdb_grant`, in, 1: CDB accepts the head entry this cycle.
- `fu_ready`, out, 1: unit can accept an issue this cycle.
- `alu_done`, out, 1: head entry valid, requesting CDB.
- `alu_result`, out, XLEN: head result.
- `alu_tagDest`, out, PREG_W: head destination tag.
- `alu_bmask`, out, BR_DEPTH: head branch mask.

## Operation
- Stage 0 computes the result combinationally from `fus_opA`/`fus_opB`/`fus_func`. It covers ADDQ, SUBQ, AND, BIC, BIS, ORNOT, XOR, EQV, SRL, SLL, SRA, CMPULT, CMPEQ, CMPULE, CMPLT and CMPLE.
  - Shifts use `opb[log2(XLEN)-1:0]`; SRA is arithmetic.
  - Compares are zero-extended 1-bit results.
  - Undefined func yields `{XLEN/64{64'hdeadbeefbaadbeef}}` truncated to XLEN.
  - MULQ is not handled here.
- Each stage i holds {valid, result, tag, bmask}. The last stage (STAGES-1) is the head.
- Advance rule: stage i loads from stage i-1 when stage i is empty, or when stage i itself advances. The head advances when `cdb_grant`. Bubbles collapse, so a stall at the head does not prevent upstream stages from filling empty slots.
- `fu_ready` = stage 0 can load (empty, or advancing this cycle). Combinational; it does not depend on `fus_en`.
- An issue with `fus_en & ~fu_ready` is a protocol error. The bench flags it; RTL ignores the issue.
- Branch resolution, applied in the same cycle to every stage and to the incoming issue:
  - If `br_pred_wrong & bmask[br_bs_ptr]`: the entry is invalidated. An incoming op is not latched.
  - Otherwise, if resolved: `bmask[br_bs_ptr]` is cleared in the stored/latched copy.
- Head outputs are combinationally corrected for the current cycle's resolution:
  - `alu_done = head_valid & ~(br_branch_resolved & br_pred_wrong & head_bmask[br_bs_ptr])`.
  - `alu_bmask` has bit `br_bs_ptr` cleared when `br_branch_resolved`.
- `cdb_grant` while `alu_done`=0 has no effect.

## Timing
- Reset: all valids cleared; `alu_done`=0, `alu_result`=0, `alu_tagDest`=0, `alu_bmask`=0, `fu_ready`=1 in the cycle after reset. Reset mid-operation discards all in-flight entries; no done is emitted.
- Latency: an op issued at edge t, with no stalls, has `alu_done`=1 during cycle t+STAGES-1 after the edge, and is consumed by grant at edge t+STAGES.
- Throughput: 1 op/cycle while granted. Capacity is STAGES entries.
- Full: all stages valid and no grant means `fu_ready`=0. Full with grant means `fu_ready`=1; issue and retire occur in the same cycle.
- Squash while `cdb_grant`=1 on a squashed head: the entry is dropped, `alu_done`=0, and the grant is ignored.
- A correct resolution and an issue with that bit set in the same cycle latch the op with the bit already cleared.

## Structure
- Shared package: `ALU_*` func encodings, and the `DATA`, `PHYS_REG`, `B_MASK`, `BS_PTR` typedefs generalised by the parameters.
- Also in the package: a `fu_pipe_entry_t` struct {valid, result, tag, bmask}.
- Reuse the existing combinational `alu` core, widened to XLEN, as stage-0 logic.
- One sub-module `fu_pipe_stage`: a single register slot with load/hold/squash/bit-clear logic. It is instantiated STAGES times via generate.

## Test plan
- Back-to-back ADDQ 3+4, SUBQ 10-1, SRA 0x8000…0>>4 with STAGES=2 and grant always 1: done on cycles 2, 3, 4 with 7, 9, 0xF800…0; `fu_ready` stays 1.
- Hold `cdb_grant`=0 for 5 cycles while issuing every cycle: exactly STAGES ops are accepted and `fu_ready` drops. On release, results retire in order with no loss or duplication.
- Fill the pipe with bmasks 0001, 0010, 0001, then resolve ptr 0 mispredicted: both 0001 entries vanish, the 0010 entry retires, and an issue in the same cycle with bmask 0001 is dropped.
- Correct resolution of ptr 1 while the head holds bmask 0010: `alu_bmask`=0000 combinationally that cycle; stored masks of upstream entries are cleared.
- Assert `reset` with 2 entries in flight and the head stalled: the next cycle has `alu_done`=0, all outputs 0, and `fu_ready`=1.
- CMPLT -1 vs 1 returns 1; CMPULT with the same operands returns 0; an undefined func returns the deadbeef pattern. Sweep STAGES=1 and 4 to confirm the latency rule.

Source files
------------

// File: rtl/alu_pipe_fu_pkg.sv
// alu_pipe_fu shared types: func codes,
// default widths and the pipe entry bundle.
package alu_pipe_fu_pkg;

  localparam int DEF_XLEN     = 64;
  localparam int DEF_BR_DEPTH = 4;
  localparam int DEF_PREG_W   = 6;

  localparam logic [63:0] BAD_PAT =
    64'hdeadbeefbaadbeef;

  typedef enum logic [4:0] {
    ALU_ADDQ   = 5'h00,
    ALU_SUBQ   = 5'h01,
    ALU_AND    = 5'h02,
    ALU_BIC    = 5'h03,
    ALU_BIS    = 5'h04,
    ALU_ORNOT  = 5'h05,
    ALU_XOR    = 5'h06,
    ALU_EQV    = 5'h07,
    ALU_SRL    = 5'h08,
    ALU_SLL    = 5'h09,
    ALU_SRA    = 5'h0a,
    ALU_MULQ   = 5'h0b,
    ALU_CMPEQ  = 5'h0c,
    ALU_CMPLT  = 5'h0d,
    ALU_CMPLE  = 5'h0e,
    ALU_CMPULT = 5'h0f,
    ALU_CMPULE = 5'h10
  } alu_func_e;

  typedef logic [DEF_XLEN-1:0]            DATA;
  typedef logic [DEF_PREG_W-1:0]          PHYS_REG;
  typedef logic [DEF_BR_DEPTH-1:0]        B_MASK;
  typedef logic [$clog2(DEF_BR_DEPTH)-1:0] BS_PTR;

  typedef struct packed {
    logic    valid;
    DATA     result;
    PHYS_REG tag;
    B_MASK   bmask;
  } fu_pipe_entry_t;

endpackage

// File: rtl/alu_pipe_fu_if.sv
// Issue, branch-resolve and CDB signals
// of the pipelined ALU functional unit.
interface alu_pipe_fu_if #(
  parameter int XLEN     = 64,
  parameter int BR_DEPTH = 4,
  parameter int PREG_W   = 6,
  parameter int BS_W     =
    (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1
);
  logic                fus_en;
  logic [XLEN-1:0]     fus_opA;
  logic [XLEN-1:0]     fus_opB;
  logic [4:0]          fus_func;
  logic [PREG_W-1:0]   fus_tagDest;
  logic [BR_DEPTH-1:0] fus_bmask;
  logic                br_branch_resolved;
  logic                br_pred_wrong;
  logic [BS_W-1:0]     br_bs_ptr;
  logic                cdb_grant;
  logic                fu_ready;
  logic                alu_done;
  logic [XLEN-1:0]     alu_result;
  logic [PREG_W-1:0]   alu_tagDest;
  logic [BR_DEPTH-1:0] alu_bmask;

  modport master (
    output fus_en, fus_opA, fus_opB,
    output fus_func, fus_tagDest, fus_bmask,
    output br_branch_resolved, br_pred_wrong,
    output br_bs_ptr, cdb_grant,
    input  fu_ready, alu_done, alu_result,
    input  alu_tagDest, alu_bmask
  );

  modport slave (
    input  fus_en, fus_opA, fus_opB,
    input  fus_func, fus_tagDest, fus_bmask,
    input  br_branch_resolved, br_pred_wrong,
    input  br_bs_ptr, cdb_grant,
    output fu_ready, alu_done, alu_result,
    output alu_tagDest, alu_bmask
  );
endinterface

// File: rtl/fu_pipe_stage.sv
// One pipe slot: load, hold, squash on
// mispredict, clear resolved mask bit.
module fu_pipe_stage #(
  parameter int XLEN     = 64,
  parameter int PREG_W   = 6,
  parameter int BR_DEPTH = 4,
  parameter int BS_W     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     in_result,
  input  logic [PREG_W-1:0]   in_tag,
  input  logic [BR_DEPTH-1:0] in_bmask,
  input  logic                br_resolved,
  input  logic                br_wrong,
  input  logic [BS_W-1:0]     br_ptr,
  output logic                valid,
  output logic [XLEN-1:0]     result,
  output logic [PREG_W-1:0]   tag,
  output logic [BR_DEPTH-1:0] bmask
);

  logic [BR_DEPTH-1:0] clr;
  logic                in_kill;
  logic                own_kill;

  assign clr = br_resolved ?
    (BR_DEPTH'(1) << br_ptr) : '0;
  assign in_kill  = br_resolved & br_wrong &
                    in_bmask[br_ptr];
  assign own_kill = br_resolved & br_wrong &
                    bmask[br_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= 1'b0;
      result <= '0;
      tag    <= '0;
      bmask  <= '0;
    end else if (load) begin
      valid  <= in_valid & ~in_kill;
      result <= in_result;
      tag    <= in_tag;
      bmask  <= in_bmask & ~clr;
    end else begin
      valid  <= valid & ~own_kill;
      bmask  <= bmask & ~clr;
    end
  end

endmodule

// File: rtl/alu_pipe_fu.sv
// Pipelined integer ALU FU: stage-0 ALU,
// STAGES collapsing slots, CDB head.
module alu_pipe_fu
  import alu_pipe_fu_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int STAGES   = 2,
  parameter int BR_DEPTH = DEF_BR_DEPTH,
  parameter int PREG_W   = DEF_PREG_W
) (
  input logic   clock,
  input logic   reset,
  alu_pipe_fu_if.slave io
);

  localparam int SH_W = $clog2(XLEN);
  localparam int BS_W =
    (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1;
  localparam int H = STAGES - 1;

  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [SH_W-1:0] sh;
  logic [XLEN-1:0] bad;
  logic [XLEN-1:0] res;

  assign opa = io.fus_opA;
  assign opb = io.fus_opB;
  assign sh  = opb[SH_W-1:0];

  always_comb begin
    bad = '0;
    for (int i = 0; i < XLEN; i++)
      bad[i] = BAD_PAT[i % 64];
  end

  always_comb begin
    res = bad;
    unique case (io.fus_func)
      ALU_ADDQ:   res = opa + opb;
      ALU_SUBQ:   res = opa - opb;
      ALU_AND:    res = opa & opb;
      ALU_BIC:    res = opa & ~opb;
      ALU_BIS:    res = opa | opb;
      ALU_ORNOT:  res = opa | ~opb;
      ALU_XOR:    res = opa ^ opb;
      ALU_EQV:    res = ~(opa ^ opb);
      ALU_SRL:    res = opa >> sh;
      ALU_SLL:    res = opa << sh;
      ALU_SRA:    res = $signed(opa) >>> sh;
      ALU_CMPEQ:  res = XLEN'(opa == opb);
      ALU_CMPULT: res = XLEN'(opa < opb);
      ALU_CMPULE: res = XLEN'(opa <= opb);
      ALU_CMPLT:
        res = XLEN'($signed(opa) < $signed(opb));
      ALU_CMPLE:
        res = XLEN'($signed(opa) <= $signed(opb));
      default:    res = bad;
    endcase
  end

  logic                qv [STAGES];
  logic [XLEN-1:0]     qr [STAGES];
  logic [PREG_W-1:0]   qt [STAGES];
  logic [BR_DEPTH-1:0] qb [STAGES];
  logic [STAGES:0]     ld;

  // a slot loads when empty or when the slot
  // downstream of it loads; the head on grant
  always_comb begin
    ld = '0;
    ld[STAGES] = io.cdb_grant;
    for (int i = STAGES - 1; i >= 0; i--)
      ld[i] = ~qv[i] | ld[i+1];
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_st
      logic                iv;
      logic [XLEN-1:0]     ir;
      logic [PREG_W-1:0]   it;
      logic [BR_DEPTH-1:0] ib;

      if (g == 0) begin : g_src
        assign iv = io.fus_en;
        assign ir = res;
        assign it = io.fus_tagDest;
        assign ib = io.fus_bmask;
      end else begin : g_src
        assign iv = qv[g-1];
        assign ir = qr[g-1];
        assign it = qt[g-1];
        assign ib = qb[g-1];
      end

      fu_pipe_stage #(
        .XLEN     (XLEN),
        .PREG_W   (PREG_W),
        .BR_DEPTH (BR_DEPTH),
        .BS_W     (BS_W)
      ) u_stage (
        .clock       (clock),
        .reset       (reset),
        .load        (ld[g]),
        .in_valid    (iv),
        .in_result   (ir),
        .in_tag      (it),
        .in_bmask    (ib),
        .br_resolved (io.br_branch_resolved),
        .br_wrong    (io.br_pred_wrong),
        .br_ptr      (io.br_bs_ptr),
        .valid       (qv[g]),
        .result      (qr[g]),
        .tag         (qt[g]),
        .bmask       (qb[g])
      );
    end
  endgenerate

  logic                head_kill;
  logic [BR_DEPTH-1:0] head_clr;

  assign head_kill = io.br_branch_resolved &
                     io.br_pred_wrong &
                     qb[H][io.br_bs_ptr];
  assign head_clr = io.br_branch_resolved ?
    (BR_DEPTH'(1) << io.br_bs_ptr) : '0;

  assign io.fu_ready    = ld[0];
  assign io.alu_done    = qv[H] & ~head_kill;
  assign io.alu_result  = qr[H];
  assign io.alu_tagDest = qt[H];
  assign io.alu_bmask   = qb[H] & ~head_clr;

endmodule

// File: tb/tb_alu_pipe_fu.sv
// Scoreboard bench for alu_pipe_fu with
// STAGES=2 main unit and 1/4 latency units.
module tb_alu_pipe_fu;
  import alu_pipe_fu_pkg::*;

  localparam int XL = 64;
  localparam int BD = 4;
  localparam int PW = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_pipe_fu_if #(
    .XLEN(XL), .BR_DEPTH(BD), .PREG_W(PW)
  ) if2 (), if1 (), if4 ();

  alu_pipe_fu #(
    .XLEN(XL), .STAGES(2),
    .BR_DEPTH(BD), .PREG_W(PW)
  ) u2 (.clock(clock), .reset(reset), .io(if2));

  alu_pipe_fu #(
    .XLEN(XL), .STAGES(1),
    .BR_DEPTH(BD), .PREG_W(PW)
  ) u1 (.clock(clock), .reset(reset), .io(if1));

  alu_pipe_fu #(
    .XLEN(XL), .STAGES(4),
    .BR_DEPTH(BD), .PREG_W(PW)
  ) u4 (.clock(clock), .reset(reset), .io(if4));

  logic sweep = 1'b0;

  assign if1.fus_en = sweep & if2.fus_en;
  assign if1.fus_opA = if2.fus_opA;
  assign if1.fus_opB = if2.fus_opB;
  assign if1.fus_func = if2.fus_func;
  assign if1.fus_tagDest = if2.fus_tagDest;
  assign if1.fus_bmask = if2.fus_bmask;
  assign if1.br_branch_resolved = 1'b0;
  assign if1.br_pred_wrong = 1'b0;
  assign if1.br_bs_ptr = '0;
  assign if1.cdb_grant = 1'b1;

  assign if4.fus_en = sweep & if2.fus_en;
  assign if4.fus_opA = if2.fus_opA;
  assign if4.fus_opB = if2.fus_opB;
  assign if4.fus_func = if2.fus_func;
  assign if4.fus_tagDest = if2.fus_tagDest;
  assign if4.fus_bmask = if2.fus_bmask;
  assign if4.br_branch_resolved = 1'b0;
  assign if4.br_pred_wrong = 1'b0;
  assign if4.br_bs_ptr = '0;
  assign if4.cdb_grant = 1'b1;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  tag;
    logic [3:0]  bm;
    int          due;
  } exp_t;

  typedef struct {
    logic [4:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
  } vec_t;

  exp_t q2[$];
  exp_t q1[$];
  exp_t q4[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] exp_res = '0;
  logic        chk_due = 1'b0;
  logic        rdy_s   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] want
  );
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(
    input logic [4:0]  f,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [5:0]  t,
    input logic [3:0]  m,
    input logic [63:0] r
  );
    if2.fus_en      = 1'b1;
    if2.fus_func    = f;
    if2.fus_opA     = a;
    if2.fus_opB     = b;
    if2.fus_tagDest = t;
    if2.fus_bmask   = m;
    exp_res         = r;
  endtask

  task automatic idle();
    if2.fus_en = 1'b0;
  endtask

  task automatic br(
    input logic res,
    input logic wrong,
    input logic [1:0] ptr
  );
    if2.br_branch_resolved = res;
    if2.br_pred_wrong      = wrong;
    if2.br_bs_ptr          = ptr;
  endtask

  task automatic drain(input int n);
    idle();
    br(1'b0, 1'b0, 2'd0);
    if2.cdb_grant = 1'b1;
    repeat (n) step();
  endtask

  always @(negedge clock) rdy_s = if2.fu_ready;

  // expected-entry model for the main unit
  always @(posedge clock) begin
    exp_t keep[$];
    exp_t e;
    logic [3:0] clr;
    logic kill_in;
    clr = if2.br_branch_resolved ?
      (4'b1 << if2.br_bs_ptr) : 4'b0;
    kill_in = if2.br_branch_resolved &&
              if2.br_pred_wrong &&
              if2.fus_bmask[if2.br_bs_ptr];
    if (reset) begin
      q2.delete();
    end else begin
      keep = {};
      foreach (q2[i]) begin
        e = q2[i];
        if (!(if2.br_branch_resolved &&
              if2.br_pred_wrong &&
              e.bm[if2.br_bs_ptr])) begin
          e.bm = e.bm & ~clr;
          keep.push_back(e);
        end
      end
      q2 = keep;
      if (if2.fus_en && rdy_s && !kill_in) begin
        e.res = exp_res;
        e.tag = if2.fus_tagDest;
        e.bm  = if2.fus_bmask & ~clr;
        e.due = chk_due ? cyc + 2 : -1;
        q2.push_back(e);
      end
    end
  end

  always @(posedge clock) begin
    exp_t e;
    if (!reset && sweep && if2.fus_en) begin
      e.res = exp_res;
      e.tag = if2.fus_tagDest;
      e.bm  = 4'b0;
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 4;
      q4.push_back(e);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    logic [3:0] m;
    if (!reset && if2.alu_done === 1'b1 &&
        if2.cdb_grant === 1'b1) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u2_spurious: got %h want none",
                 if2.alu_result);
      end else begin
        e = q2.pop_front();
        m = e.bm;
        if (if2.br_branch_resolved)
          m[if2.br_bs_ptr] = 1'b0;
        chk("u2_result", if2.alu_result, e.res);
        chk("u2_tag", 64'(if2.alu_tagDest),
            64'(e.tag));
        chk("u2_bmask", 64'(if2.alu_bmask),
            64'(m));
        if (e.due >= 0)
          chk("u2_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && if1.alu_done === 1'b1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u1_spurious: got %h want none",
                 if1.alu_result);
      end else begin
        e = q1.pop_front();
        chk("u1_result", if1.alu_result, e.res);
        chk("u1_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset && if4.alu_done === 1'b1) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u4_spurious: got %h want none",
                 if4.alu_result);
      end else begin
        e = q4.pop_front();
        chk("u4_result", if4.alu_result, e.res);
        chk("u4_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  vec_t vt [16];
  int   acc;

  initial begin
    vt = '{
      '{ALU_ADDQ, 64'd3, 64'd4, 64'd7},
      '{ALU_SUBQ, 64'd10, 64'd1, 64'd9},
      '{ALU_SRA, 64'h8000000000000000, 64'd4,
        64'hf800000000000000},
      '{ALU_CMPLT, 64'hffffffffffffffff,
        64'd1, 64'd1},
      '{ALU_CMPULT, 64'hffffffffffffffff,
        64'd1, 64'd0},
      '{5'h1f, 64'd1, 64'd2,
        64'hdeadbeefbaadbeef},
      '{ALU_AND, 64'hf0f0, 64'hff00, 64'hf000},
      '{ALU_BIC, 64'hff, 64'h0f, 64'hf0},
      '{ALU_BIS, 64'h1, 64'h2, 64'h3},
      '{ALU_ORNOT, 64'h0, 64'h0,
        64'hffffffffffffffff},
      '{ALU_XOR, 64'hff, 64'h0f, 64'hf0},
      '{ALU_EQV, 64'h55, 64'h55,
        64'hffffffffffffffff},
      '{ALU_SRL, 64'h8000000000000000,
        64'd63, 64'd1},
      '{ALU_SLL, 64'd1, 64'd68, 64'h10},
      '{ALU_CMPEQ, 64'd5, 64'd5, 64'd1},
      '{ALU_CMPLE, 64'd2, 64'd2, 64'd1}
    };

    if2.fus_en = 1'b0;
    if2.fus_opA = '0;
    if2.fus_opB = '0;
    if2.fus_func = '0;
    if2.fus_tagDest = '0;
    if2.fus_bmask = '0;
    if2.cdb_grant = 1'b1;
    br(1'b0, 1'b0, 2'd0);

    repeat (2) step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_done", 64'(if2.alu_done), 64'd0);
    chk("rst_result", if2.alu_result, 64'd0);
    chk("rst_tag", 64'(if2.alu_tagDest), 64'd0);
    chk("rst_bmask", 64'(if2.alu_bmask), 64'd0);
    chk("rst_ready", 64'(if2.fu_ready), 64'd1);

    // back-to-back, grant always high
    chk_due = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      issue(vt[i].f, vt[i].a, vt[i].b,
            6'(i + 1), 4'b0, vt[i].r);
      @(negedge clock);
      chk("b2b_ready", 64'(if2.fu_ready), 64'd1);
    end
    step();
    chk_due = 1'b0;
    drain(4);

    // stall at the head, issue every cycle
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if2.cdb_grant = 1'b0;
      issue(ALU_ADDQ, 64'(k), 64'd100,
            6'(20 + k), 4'b0, 64'(k + 100));
      @(negedge clock);
      if (if2.fu_ready) acc++;
    end
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_ready", 64'(if2.fu_ready), 64'd0);
    step();
    if2.cdb_grant = 1'b1;
    issue(ALU_ADDQ, 64'd7, 64'd7, 6'd30,
          4'b0, 64'd14);
    @(negedge clock);
    chk("full_grant_ready",
        64'(if2.fu_ready), 64'd1);
    step();
    drain(4);

    // mispredict on ptr 0 with squashed head
    if2.cdb_grant = 1'b0;
    issue(ALU_XOR, 64'd1, 64'd3, 6'd40,
          4'b0001, 64'd2);
    step();
    issue(ALU_AND, 64'd6, 64'd3, 6'd41,
          4'b0010, 64'd2);
    step();
    if2.cdb_grant = 1'b1;
    br(1'b1, 1'b1, 2'd0);
    issue(ALU_ADDQ, 64'd1, 64'd1, 6'd42,
          4'b0001, 64'd2);
    @(negedge clock);
    chk("squash_done", 64'(if2.alu_done), 64'd0);
    chk("squash_ready", 64'(if2.fu_ready), 64'd1);
    step();
    drain(4);

    // correct resolve of ptr 1
    if2.cdb_grant = 1'b0;
    issue(ALU_ADDQ, 64'd2, 64'd2, 6'd50,
          4'b0010, 64'd4);
    step();
    issue(ALU_ADDQ, 64'd3, 64'd3, 6'd51,
          4'b0110, 64'd6);
    step();
    if2.cdb_grant = 1'b1;
    br(1'b1, 1'b0, 2'd1);
    issue(ALU_ADDQ, 64'd4, 64'd4, 6'd52,
          4'b0010, 64'd8);
    @(negedge clock);
    chk("resolve_bmask", 64'(if2.alu_bmask),
        64'd0);
    step();
    drain(4);

    // reset with two entries stalled
    if2.cdb_grant = 1'b0;
    issue(ALU_ADDQ, 64'd1, 64'd2, 6'd60,
          4'b0, 64'd3);
    step();
    issue(ALU_ADDQ, 64'd5, 64'd2, 6'd61,
          4'b0, 64'd7);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_done", 64'(if2.alu_done), 64'd0);
    chk("mid_rst_result", if2.alu_result, 64'd0);
    chk("mid_rst_tag", 64'(if2.alu_tagDest),
        64'd0);
    chk("mid_rst_bmask", 64'(if2.alu_bmask),
        64'd0);
    chk("mid_rst_ready", 64'(if2.fu_ready), 64'd1);
    step();
    drain(4);

    // latency sweep on STAGES 1, 2, 4
    sweep = 1'b1;
    chk_due = 1'b1;
    issue(ALU_ADDQ, 64'd5, 64'd6, 6'd70,
          4'b0, 64'd11);
    step();
    issue(ALU_CMPLT, 64'hffffffffffffffff,
          64'd1, 6'd71, 4'b0, 64'd1);
    step();
    idle();
    sweep = 1'b0;
    chk_due = 1'b0;
    drain(8);

    chk("u2_drained", 64'(q2.size()), 64'd0);
    chk("u1_drained", 64'(q1.size()), 64'd0);
    chk("u4_drained", 64'(q4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
